// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the hazard/redirect sources and the PC sequencer.
// The sequencer takes the slave modport; whatever drives the requests takes master.
interface pc_sequencer_if;
    logic        stall;
    logic [31:0] pc_incr;
    logic        exc_req;
    logic [31:0] exc_epc;
    logic        eret_req;
    logic        branch_req;
    logic [31:0] branch_target;
    logic        jump_req;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        flush_ex_mem;
    logic [31:0] epc;
    logic        redirect_pend;

    modport master (
        output stall, pc_incr,
        output exc_req, exc_epc, eret_req,
        output branch_req, branch_target,
        output jump_req, jump_target,
        input  pc, fetch_valid, epc, redirect_pend,
        input  flush_if_id, flush_id_ex, flush_ex_mem
    );

    modport slave (
        input  stall, pc_incr,
        input  exc_req, exc_epc, eret_req,
        input  branch_req, branch_target,
        input  jump_req, jump_target,
        output pc, fetch_valid, epc, redirect_pend,
        output flush_if_id, flush_id_ex, flush_ex_mem
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: redirect arbitration, stalled-redirect capture,
// EPC storage, per-stage flushes and post-reset boot delay.
module pc_sequencer #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_1000,
    parameter logic [31:0] EXC_ADDR  = 32'h0000_2000,
    parameter int          BOOT_WAIT = 4
) (
    input logic          i_clk,
    input logic          i_rst,
    pc_sequencer_if.slave bus
);
    localparam int CW = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(BOOT_WAIT - 1);

    // Redirect priority levels; 0 means plain sequential fetch.
    localparam logic [2:0] P_NONE = 3'd0;
    localparam logic [2:0] P_JMP  = 3'd1;
    localparam logic [2:0] P_BR   = 3'd2;
    localparam logic [2:0] P_ERET = 3'd3;
    localparam logic [2:0] P_EXC  = 3'd4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_PEND
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nxt;
    logic [31:0]   r_epc;
    logic [31:0]   r_pend_tgt;
    logic [31:0]   w_pend_tgt_nxt;
    logic [2:0]    r_pend_pri;
    logic [2:0]    w_pend_pri_nxt;
    logic [2:0]    w_pri;
    logic [31:0]   w_raw;
    logic [31:0]   w_tgt;
    logic          w_acc;

    // Pick the highest-priority request and its (word-aligned) target.
    always_comb begin
        w_pri = P_NONE;
        w_raw = bus.pc_incr;
        if (bus.exc_req) begin
            w_pri = P_EXC;
            w_raw = EXC_ADDR;
        end else if (bus.eret_req) begin
            w_pri = P_ERET;
            w_raw = r_epc;
        end else if (bus.branch_req) begin
            w_pri = P_BR;
            w_raw = bus.branch_target;
        end else if (bus.jump_req) begin
            w_pri = P_JMP;
            w_raw = bus.jump_target;
        end
        w_tgt = {w_raw[31:2], 2'b00};
    end

    // A request is accepted when it wins in RUN or outranks the held one in PEND.
    always_comb begin
        w_acc = 1'b0;
        if (r_state == S_RUN)
            w_acc = (w_pri != P_NONE);
        else if (r_state == S_PEND)
            w_acc = (w_pri > r_pend_pri);
    end

    // Flushes fire with acceptance, regardless of stall.
    always_comb begin
        bus.flush_if_id  = w_acc;
        bus.flush_id_ex  = w_acc && (w_pri >= P_BR);
        bus.flush_ex_mem = w_acc && (w_pri >= P_ERET);
    end

    // Next-state, next-PC and pending-redirect decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_tgt_nxt = r_pend_tgt;
        w_pend_pri_nxt = r_pend_pri;
        case (r_state)
            S_BOOT: begin
                if (r_cnt == LAST)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!bus.stall) begin
                    w_pc_nxt = w_tgt;
                end else if (w_pri != P_NONE) begin
                    w_state_nxt    = S_PEND;
                    w_pend_tgt_nxt = w_tgt;
                    w_pend_pri_nxt = w_pri;
                end
            end
            S_PEND: begin
                if (!bus.stall) begin
                    w_pc_nxt    = w_acc ? w_tgt : r_pend_tgt;
                    w_state_nxt = S_RUN;
                end else if (w_acc) begin
                    w_pend_tgt_nxt = w_tgt;
                    w_pend_pri_nxt = w_pri;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // State, PC, EPC and pending-redirect registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_BOOT;
            r_cnt      <= '0;
            r_pc       <= BOOT_ADDR;
            r_epc      <= '0;
            r_pend_tgt <= '0;
            r_pend_pri <= P_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= (r_state == S_BOOT) ? r_cnt + 1'b1 : '0;
            r_pc       <= w_pc_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_pend_pri <= w_pend_pri_nxt;
            if (w_acc && (w_pri == P_EXC))
                r_epc <= bus.exc_epc;
        end
    end

    assign bus.pc            = r_pc;
    assign bus.epc           = r_epc;
    assign bus.fetch_valid   = (r_state != S_BOOT);
    assign bus.redirect_pend = (r_state == S_PEND);
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic,
// all checked against a cycle-level behavioural model.
module tb_pc_sequencer;
    localparam logic [31:0] BOOT = 32'h0000_1000;
    localparam logic [31:0] EXC  = 32'h0000_2000;
    localparam int          BW   = 4;
    localparam logic [31:0] MSK  = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .BOOT_ADDR(BOOT),
        .EXC_ADDR (EXC),
        .BOOT_WAIT(BW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_ptgt;
    int          m_boot;
    int          m_ppri;
    bit          m_pend;
    bit          m_known = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic drive(input logic r, input logic s,
                         input logic e, input logic er,
                         input logic b, input logic j,
                         input logic [31:0] ee,
                         input logic [31:0] bt,
                         input logic [31:0] jt,
                         input logic [31:0] pi);
        rst               = r;
        bus.stall         = s;
        bus.exc_req       = e;
        bus.eret_req      = er;
        bus.branch_req    = b;
        bus.jump_req      = j;
        bus.exc_epc       = ee;
        bus.branch_target = bt;
        bus.jump_target   = jt;
        bus.pc_incr       = pi;
    endtask

    task automatic idle(input logic s, input logic [31:0] pi);
        drive(1'b0, s, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, pi);
    endtask

    // One clock: check DUT against model mid-cycle, then advance the model.
    task automatic tick();
        int          p;
        logic [31:0] tg [5];
        bit          acc;
        @(negedge clk);
        p = 0;
        if (bus.jump_req)   p = 1;
        if (bus.branch_req) p = 2;
        if (bus.eret_req)   p = 3;
        if (bus.exc_req)    p = 4;
        tg[0] = bus.pc_incr;
        tg[1] = bus.jump_target;
        tg[2] = bus.branch_target;
        tg[3] = m_epc;
        tg[4] = EXC;
        acc = m_known && (m_boot == 0) && (p > (m_pend ? m_ppri : 0));
        if (m_known) begin
            check("pc",      bus.pc, m_pc);
            check("epc",     bus.epc, m_epc);
            check("fvalid",  32'(bus.fetch_valid), 32'(m_boot == 0));
            check("pend",    32'(bus.redirect_pend), 32'(m_pend));
            check("fl_ifid", 32'(bus.flush_if_id), 32'(acc));
            check("fl_idex", 32'(bus.flush_id_ex), 32'(acc && p >= 2));
            check("fl_exmm", 32'(bus.flush_ex_mem), 32'(acc && p >= 3));
        end
        if (rst) begin
            m_known = 1'b1;
            m_pc    = BOOT;
            m_epc   = '0;
            m_boot  = BW;
            m_pend  = 1'b0;
            m_ppri  = 0;
            m_ptgt  = '0;
        end else if (m_known) begin
            if (m_boot > 0) begin
                m_boot--;
            end else begin
                if (acc && p == 4)
                    m_epc = bus.exc_epc;
                if (!bus.stall) begin
                    if (acc)
                        m_pc = tg[p] & MSK;
                    else if (m_pend)
                        m_pc = m_ptgt;
                    else
                        m_pc = tg[0] & MSK;
                    m_pend = 1'b0;
                end else if (acc) begin
                    m_pend = 1'b1;
                    m_ptgt = tg[p] & MSK;
                    m_ppri = p;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, then boot with a jump that must be ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        idle(1'b0, 32'h1004);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'h1400, 32'h1004);
        #1;
        check("boot_noflush", 32'(bus.flush_if_id), 32'd0);
        tick();
        idle(1'b0, 32'h1004);
        tick();
        tick();
        check("boot_fv", 32'(bus.fetch_valid), 32'd1);
        check("boot_pc", bus.pc, BOOT);

        // branch + jump together: branch wins
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
              '0, 32'h1800, 32'h1400, 32'h1004);
        #1;
        check("br_ifid", 32'(bus.flush_if_id), 32'd1);
        check("br_idex", 32'(bus.flush_id_ex), 32'd1);
        check("br_exmm", 32'(bus.flush_ex_mem), 32'd0);
        tick();
        check("br_pc", bus.pc, 32'h1800);

        // stalled jump captured, then replaced by a branch
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
              '0, '0, 32'h1400, 32'h1804);
        tick();
        check("st_pend", 32'(bus.redirect_pend), 32'd1);
        check("st_pc", bus.pc, 32'h1800);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
              '0, 32'h1600, '0, 32'h1804);
        #1;
        check("repl_idex", 32'(bus.flush_id_ex), 32'd1);
        tick();
        idle(1'b0, 32'h1804);
        tick();
        check("rel_pc", bus.pc, 32'h1600);
        check("rel_pend", 32'(bus.redirect_pend), 32'd0);

        // pending branch, lower-priority jump dropped
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
              '0, 32'h1700, '0, 32'h1604);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
              '0, '0, 32'h1900, 32'h1604);
        #1;
        check("drop_ifid", 32'(bus.flush_if_id), 32'd0);
        tick();
        idle(1'b0, 32'h1604);
        tick();
        check("drop_pc", bus.pc, 32'h1700);

        // exception beats eret, then eret returns to epc
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
              32'h1234, '0, '0, 32'h1704);
        #1;
        check("exc_exmm", 32'(bus.flush_ex_mem), 32'd1);
        tick();
        check("exc_pc", bus.pc, EXC);
        check("exc_epc", bus.epc, 32'h1234);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 32'h2004);
        tick();
        check("eret_pc", bus.pc, 32'h1234);

        // reset while pending discards the redirect
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
              '0, '0, 32'h1ABC, 32'h1238);
        tick();
        check("r_pend", 32'(bus.redirect_pend), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        check("r_pc", bus.pc, BOOT);
        check("r_pend0", 32'(bus.redirect_pend), 32'd0);
        idle(1'b0, 32'h1004);
        for (int i = 0; i < BW; i++)
            tick();
        tick();
        check("r_seq_pc", bus.pc, 32'h1004);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = ($urandom_range(0, 149) == 0);
            drive(r,
                  ($urandom_range(0, 2) == 0),
                  !r && ($urandom_range(0, 9) == 0),
                  !r && ($urandom_range(0, 7) == 0),
                  !r && ($urandom_range(0, 3) == 0),
                  !r && ($urandom_range(0, 3) == 0),
                  $urandom(), $urandom(), $urandom(),
                  ($urandom_range(0, 3) == 0) ? $urandom() : m_pc + 32'd4);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
